st_frame_gen: RTL and testbench
===============================

# st_frame_gen

Synthesisable Avalon-ST packet source for the sensor algorithm pipeline (cluster/centroid stages). It emits configurable sensor frames of N words with selectable data patterns, a programmable inter-packet gap and a packet count, and honours sink back-pressure. It replaces hand-coded testbench stimulus so that the same generator can drive `algo_top_cl` in simulation and on hardware (injected ahead of the sensor deserialiser through a mux).

## Interface
- `DATA_W`, 32, data word width (≥16)
- `EMPTY_W`, 2, width of `src_empty`
- `CNT_W`, 16, width of word/gap/packet counters
- `clk`  in  1  sole clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; latches config and begins a run (ignored while `busy`)
- `stop`  in  1  request to end the run at the next packet boundary
- `cfg_mode`  in  2  0 CONST, 1 INC, 2 LFSR, 3 PKT_INC
- `cfg_seed`  in  DATA_W  base value / LFSR seed
- `cfg_words`  in  CNT_W  words per packet (0 treated as 1)
- `cfg_gap`  in  CNT_W  idle cycles between packets
- `cfg_num_pkts`  in  CNT_W  packets per run (0 = unlimited)
- `src_data`  out  DATA_W  stream data
- `src_valid`  out  1  stream valid
- `src_ready`  in  1  sink ready (ready latency 0)
- `src_startofpacket`  out  1  first word of packet
- `src_endofpacket`  out  1  last word of packet
- `src_empty`  out  EMPTY_W  constant 0
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse at run completion
- `pkt_cnt`  out  CNT_W  packets fully accepted in the current/last run

## Operation
- FSM states: IDLE, SEND, GAP.
- IDLE: `start` latches all `cfg_*` into shadow registers, clears `pkt_cnt`, word index k=0, packet index p=0 → SEND.
- SEND: `src_valid`=1; a word is accepted on `src_valid && src_ready`; on accept k increments. `src_startofpacket` = (k==0); `src_endofpacket` = (k==words−1).
- On accepting the last word: `pkt_cnt`++, p++, k=0. If (num_pkts≠0 and p+1==num_pkts) or stop pending → IDLE with `done` pulse; else if gap==0 → stay in SEND (back-to-back, next word carries SOP); else → GAP.
- GAP: counts gap cycles with `src_valid`=0, then → SEND; a pending stop in GAP → IDLE with `done`.
- `stop` is sticky until consumed; mid-packet stop completes the current packet (packets never truncated). `stop` in IDLE is ignored.
- Data patterns (all arithmetic modulo 2^DATA_W):
  - CONST: every word = seed.
  - INC: word k = seed + k, restarting at each packet.
  - LFSR: Galois LFSR, taps 0x80200003 on the low 32 bits (DATA_W>32 zero-extends); a seed of 0 is replaced by 1. Advances per accepted word and continues across packets.
  - PKT_INC: every word of packet p = seed + p.

## Timing
- Reset values: `src_valid`=0, `src_startofpacket`=0, `src_endofpacket`=0, `src_data`=0, `src_empty`=0, `busy`=0, `done`=0, `pkt_cnt`=0, state IDLE, stop-pending cleared. Reset mid-packet aborts immediately (the only permitted truncation).
- `start` at cycle T → first `src_valid` at T+1.
- Held word: while `src_valid && !src_ready`, `src_data`/SOP/EOP stay stable.
- Throughput: 1 word/cycle with `src_ready` high; packet period = words + gap cycles.
- `busy` is high from T+1 through the cycle `done` pulses, and is low the cycle after.
- `done` asserts in the cycle after the final accept, i.e. the first IDLE cycle.
- `start` coinciding with the `done` cycle is accepted (a new run begins).

## Structure
- Package `st_frame_gen_pkg`: mode enum (CONST/INC/LFSR/PKT_INC), state enum, LFSR tap constant 0x80200003.
- One sub-module, `st_lfsr`: load/advance enable, DATA_W output.

## Test plan
- INC, seed 600000, words 163, gap 0, pkts 2, ready=1 → 326 beats; data 600000..600162 twice; SOP on beats 0 and 163; EOP on beats 162 and 325; `done` once; `pkt_cnt`=2.
- PKT_INC, seed 7000000, words 4, gap 3, pkts 3 → packets of 7000000, 7000001, 7000002; exactly 3 invalid cycles between packets.
- Back-pressure: INC, words 8, `src_ready` toggling 1/0 → data/SOP/EOP held while not ready; 8 accepts; no duplicate or skipped word.
- `stop` at word 2 of packet 1, num_pkts 0 → packet 1 completes through EOP; `done` pulses; `pkt_cnt`=2.
- LFSR, seed 0, words 3 → first word 1, then the Galois sequence from 1; `cfg_words`=0 → single beat with SOP and EOP both high.
- `rst` asserted mid-packet → next cycle `src_valid`=0, `busy`=0, `pkt_cnt`=0; a later `start` restarts from k=0.

Source files
------------

// File: rtl/st_frame_gen_pkg.sv
// Shared types and constants for the Avalon-ST frame generator.
package st_frame_gen_pkg;

    typedef enum logic [1:0] {
        MODE_CONST   = 2'd0,
        MODE_INC     = 2'd1,
        MODE_LFSR    = 2'd2,
        MODE_PKT_INC = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Right-shifting Galois step: the bit shifted out selects the tap mask.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/st_lfsr.sv
// 32-bit Galois LFSR; the state is zero-extended or truncated to DATA_W on output.
module st_lfsr
    import st_frame_gen_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] value
);

    logic [31:0] seed32;
    logic [31:0] lfsr_q;

    assign seed32 = 32'(seed);

    // An all-zero state would lock up, so a zero seed starts from 1.
    always_ff @(posedge clk) begin
        if (rst)
            lfsr_q <= 32'd1;
        else if (load)
            lfsr_q <= (seed32 == 32'd0) ? 32'd1 : seed32;
        else if (advance)
            lfsr_q <= lfsr_step(lfsr_q);
    end

    assign value = DATA_W'(lfsr_q);

endmodule

// File: rtl/st_frame_gen.sv
// Avalon-ST packet source: configurable frames, data patterns, gaps and packet count.
//   state   | meaning
//   IDLE    | waiting for start; config shadows hold the last run
//   SEND    | presenting word k of packet pkt_cnt
//   GAP     | inter-packet idle cycles, src_valid low
module st_frame_gen
    import st_frame_gen_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         cfg_mode,
    input  logic [DATA_W-1:0]  cfg_seed,
    input  logic [CNT_W-1:0]   cfg_words,
    input  logic [CNT_W-1:0]   cfg_gap,
    input  logic [CNT_W-1:0]   cfg_num_pkts,
    output logic [DATA_W-1:0]  src_data,
    output logic               src_valid,
    input  logic               src_ready,
    output logic               src_startofpacket,
    output logic               src_endofpacket,
    output logic [EMPTY_W-1:0] src_empty,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   pkt_cnt
);

    state_e              state, state_nxt;
    mode_e               mode_q;
    logic [DATA_W-1:0]   seed_q;
    logic [CNT_W-1:0]    words_m1, gap_q, num_q, k, gap_cnt;
    logic                stop_pend, done_q;
    logic [DATA_W-1:0]   lfsr_val;
    logic                launch, accept, last_word, stop_now, run_end;

    assign launch    = (state == ST_IDLE) && start;
    assign accept    = (state == ST_SEND) && src_ready;
    assign last_word = (k == words_m1);
    assign stop_now  = stop_pend || stop;
    assign run_end   = ((num_q != '0) && (pkt_cnt + CNT_W'(1) == num_q)) || stop_now;

    st_lfsr #(.DATA_W(DATA_W)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (launch),
        .advance (accept),
        .seed    (cfg_seed),
        .value   (lfsr_val)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_SEND;
            ST_SEND: begin
                if (accept && last_word) begin
                    if (run_end)
                        state_nxt = ST_IDLE;
                    else if (gap_q != '0)
                        state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (stop_now)
                    state_nxt = ST_IDLE;
                else if (gap_cnt == '0)
                    state_nxt = ST_SEND;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_CONST;
            seed_q    <= '0;
            words_m1  <= '0;
            gap_q     <= '0;
            num_q     <= '0;
            k         <= '0;
            gap_cnt   <= '0;
            pkt_cnt   <= '0;
            stop_pend <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state != ST_IDLE) && (state_nxt == ST_IDLE);
            if (state == ST_IDLE || state_nxt == ST_IDLE)
                stop_pend <= 1'b0;
            else if (stop)
                stop_pend <= 1'b1;
            if (launch) begin
                mode_q   <= mode_e'(cfg_mode);
                seed_q   <= cfg_seed;
                words_m1 <= (cfg_words == '0) ? '0 : cfg_words - CNT_W'(1);
                gap_q    <= cfg_gap;
                num_q    <= cfg_num_pkts;
                k        <= '0;
                pkt_cnt  <= '0;
            end
            if (accept) begin
                if (last_word) begin
                    k       <= '0;
                    pkt_cnt <= pkt_cnt + CNT_W'(1);
                end else begin
                    k <= k + CNT_W'(1);
                end
            end
            // Down-counter reaches zero on the last idle cycle of the gap.
            if (state == ST_SEND && state_nxt == ST_GAP)
                gap_cnt <= gap_q - CNT_W'(1);
            else if (state == ST_GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        src_valid         = 1'b0;
        src_startofpacket = 1'b0;
        src_endofpacket   = 1'b0;
        src_data          = '0;
        if (state == ST_SEND) begin
            src_valid         = 1'b1;
            src_startofpacket = (k == '0);
            src_endofpacket   = last_word;
            case (mode_q)
                MODE_CONST: src_data = seed_q;
                MODE_INC:   src_data = seed_q + DATA_W'(k);
                MODE_LFSR:  src_data = lfsr_val;
                default:    src_data = seed_q + DATA_W'(pkt_cnt);
            endcase
        end
    end

    assign busy      = (state != ST_IDLE) || done_q;
    assign done      = done_q;
    assign src_empty = '0;

endmodule

// File: tb/tb_st_frame_gen.sv
// Directed bench for st_frame_gen: a beat-level model checked against every accepted word.
module tb_st_frame_gen;
    localparam int DATA_W = 32, EMPTY_W = 2, CNT_W = 16;

    logic               clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, src_ready = 1'b1;
    logic [1:0]         cfg_mode = 2'd0;
    logic [DATA_W-1:0]  cfg_seed = '0;
    logic [CNT_W-1:0]   cfg_words = '0, cfg_gap = '0, cfg_num_pkts = '0;
    logic [DATA_W-1:0]  src_data;
    logic               src_valid, src_startofpacket, src_endofpacket, busy, done;
    logic [EMPTY_W-1:0] src_empty;
    logic [CNT_W-1:0]   pkt_cnt;

    st_frame_gen #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_mode(cfg_mode),
        .cfg_seed(cfg_seed), .cfg_words(cfg_words), .cfg_gap(cfg_gap),
        .cfg_num_pkts(cfg_num_pkts), .src_data(src_data), .src_valid(src_valid),
        .src_ready(src_ready), .src_startofpacket(src_startofpacket),
        .src_endofpacket(src_endofpacket), .src_empty(src_empty), .busy(busy),
        .done(done), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        s;
        logic        e;
    } beat_t;

    int total = 0, bad = 0;
    beat_t exp_q[$];
    beat_t b;
    logic [31:0] acc_d[$];
    logic acc_s[$], acc_e[$];
    int idle_runs[$];
    int inv_run = 0, done_cnt = 0;
    logic chk_en = 1'b0, held = 1'b0, h_s, h_e;
    logic [31:0] h_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] galois(input logic [31:0] x);
        if (x[0]) return (x >> 1) ^ 32'h8020_0003;
        return x >> 1;
    endfunction

    // Expected accepted beats for one run, from the pattern definitions.
    task automatic build(input int mode, input logic [31:0] seed, input int words, input int npk);
        int w;
        logic [31:0] lf;
        beat_t nb;
        w  = (words == 0) ? 1 : words;
        lf = (seed == 0) ? 32'd1 : seed;
        for (int p = 0; p < npk; p++)
            for (int kk = 0; kk < w; kk++) begin
                case (mode)
                    0: nb.d = seed;
                    1: nb.d = seed + kk;
                    2: begin nb.d = lf; lf = galois(lf); end
                    default: nb.d = seed + p;
                endcase
                nb.s = (kk == 0);
                nb.e = (kk == w - 1);
                exp_q.push_back(nb);
            end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("empty", 64'(src_empty), 64'd0);
            if (done) done_cnt++;
            if (held) begin
                check("hold_valid", 64'(src_valid), 64'd1);
                check("hold_data", 64'(src_data), 64'(h_d));
                check("hold_sop", 64'(src_startofpacket), 64'(h_s));
                check("hold_eop", 64'(src_endofpacket), 64'(h_e));
            end
            if (src_valid && src_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'd1, 64'd0);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", 64'(src_data), 64'(b.d));
                    check("beat_sop", 64'(src_startofpacket), 64'(b.s));
                    check("beat_eop", 64'(src_endofpacket), 64'(b.e));
                end
                acc_d.push_back(src_data);
                acc_s.push_back(src_startofpacket);
                acc_e.push_back(src_endofpacket);
            end
            held = src_valid && !src_ready;
            h_d  = src_data;
            h_s  = src_startofpacket;
            h_e  = src_endofpacket;
            if (src_valid) begin
                if (inv_run > 0) idle_runs.push_back(inv_run);
                inv_run = 0;
            end else if (busy && !done) begin
                inv_run++;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic clear_logs();
        exp_q.delete();
        acc_d.delete();
        acc_s.delete();
        acc_e.delete();
        idle_runs.delete();
        inv_run = 0;
    endtask

    task automatic set_cfg(input int mode, input logic [31:0] seed, input int words,
                           input int gap, input int npk);
        cfg_mode     = 2'(mode);
        cfg_seed     = seed;
        cfg_words    = CNT_W'(words);
        cfg_gap      = CNT_W'(gap);
        cfg_num_pkts = CNT_W'(npk);
    endtask

    task automatic cfg_start(input int mode, input logic [31:0] seed, input int words,
                             input int gap, input int npk);
        build(mode, seed, words, npk);
        set_cfg(mode, seed, words, gap, npk);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("valid_T1", 64'(src_valid), 64'd1);
        check("busy_T1", 64'(busy), 64'd1);
        // Scrambled live config must not disturb the latched run.
        set_cfg(3 - mode, 32'hDEAD_BEEF, 1, 7, 1);
    endtask

    task automatic wait_done(input string name, input int budget, input bit toggle);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (toggle) src_ready = ~src_ready;
            if (done_cnt != d0) seen = 1'b1;
        end
        src_ready = 1'b1;
        if (!seen) begin
            check(name, 64'd0, 64'd1);
        end else begin
            check("busy_after_done", 64'(busy), 64'd0);
            check("done_pulse_width", 64'(done), 64'd0);
        end
        repeat (2) @(posedge clk);
        #1 check("done_once", 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic wait_beats(input string name, input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1;
            if (acc_d.size() >= n) ok = 1'b1;
        end
        if (!ok) check(name, 64'd0, 64'd1);
    endtask

    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(src_valid), 64'd0);
        check("rst_sop", 64'(src_startofpacket), 64'd0);
        check("rst_eop", 64'(src_endofpacket), 64'd0);
        check("rst_data", 64'(src_data), 64'd0);
        check("rst_empty", 64'(src_empty), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;

        // INC back-to-back packets
        clear_logs();
        cfg_start(1, 32'd600000, 163, 0, 2);
        wait_done("t1_timeout", 400, 1'b0);
        check("t1_pkt_cnt", 64'(pkt_cnt), 64'd2);
        check("t1_beats", 64'(acc_d.size()), 64'd326);
        check("t1_left", 64'(exp_q.size()), 64'd0);
        check("t1_d162", 64'(acc_d[162]), 64'd600162);
        check("t1_d163", 64'(acc_d[163]), 64'd600000);
        check("t1_sop163", 64'(acc_s[163]), 64'd1);
        check("t1_eop162", 64'(acc_e[162]), 64'd1);
        check("t1_eop325", 64'(acc_e[325]), 64'd1);

        // PKT_INC with a 3-cycle gap
        clear_logs();
        cfg_start(3, 32'd7000000, 4, 3, 3);
        wait_done("t2_timeout", 60, 1'b0);
        check("t2_pkt_cnt", 64'(pkt_cnt), 64'd3);
        check("t2_gaps", 64'(idle_runs.size()), 64'd2);
        check("t2_gap0", 64'(idle_runs[0]), 64'd3);
        check("t2_gap1", 64'(idle_runs[1]), 64'd3);
        check("t2_d4", 64'(acc_d[4]), 64'd7000001);
        check("t2_d11", 64'(acc_d[11]), 64'd7000002);

        // back-pressure
        clear_logs();
        cfg_start(1, 32'h1234, 8, 0, 1);
        wait_done("t3_timeout", 60, 1'b1);
        check("t3_beats", 64'(acc_d.size()), 64'd8);
        check("t3_d7", 64'(acc_d[7]), 64'h123b);
        check("t3_left", 64'(exp_q.size()), 64'd0);

        // stop mid-packet 1 in unlimited mode
        clear_logs();
        cfg_start(1, 32'd100, 5, 2, 0);
        exp_q.delete();
        build(1, 32'd100, 5, 2);
        wait_beats("t4_reach", 7);
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_done("t4_timeout", 40, 1'b0);
        check("t4_pkt_cnt", 64'(pkt_cnt), 64'd2);
        check("t4_beats", 64'(acc_d.size()), 64'd10);
        check("t4_d9", 64'(acc_d[9]), 64'd104);
        check("t4_eop9", 64'(acc_e[9]), 64'd1);

        // LFSR with zero seed, continuing across packets
        clear_logs();
        cfg_start(2, 32'd0, 3, 1, 2);
        wait_done("t5_timeout", 40, 1'b0);
        check("t5_beats", 64'(acc_d.size()), 64'd6);
        check("t5_d0", 64'(acc_d[0]), 64'd1);
        check("t5_d1", 64'(acc_d[1]), 64'h8020_0003);
        check("t5_d2", 64'(acc_d[2]), 64'hC030_0002);
        check("t5_d3", 64'(acc_d[3]), 64'h6018_0001);

        // zero words means a single beat
        clear_logs();
        cfg_start(0, 32'hABCD, 0, 0, 1);
        wait_done("t5b_timeout", 20, 1'b0);
        check("t5b_beats", 64'(acc_d.size()), 64'd1);
        check("t5b_sop", 64'(acc_s[0]), 64'd1);
        check("t5b_eop", 64'(acc_e[0]), 64'd1);
        check("t5b_data", 64'(acc_d[0]), 64'hABCD);

        // reset mid-packet, then restart
        clear_logs();
        cfg_start(1, 32'd9, 10, 0, 1);
        wait_beats("t6_reach", 3);
        rst = 1'b1;
        chk_en = 1'b0;
        @(posedge clk); #1;
        check("t6_valid", 64'(src_valid), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("t6_sop", 64'(src_startofpacket), 64'd0);
        rst = 1'b0;
        clear_logs();
        chk_en = 1'b1;
        cfg_start(1, 32'd50, 4, 0, 1);
        wait_done("t6_timeout", 20, 1'b0);
        check("t6_d0", 64'(acc_d[0]), 64'd50);
        check("t6_sop0", 64'(acc_s[0]), 64'd1);
        check("t6_beats", 64'(acc_d.size()), 64'd4);

        // start in the done cycle begins a new run
        clear_logs();
        cfg_start(0, 32'h55, 2, 0, 1);
        build(1, 32'h70, 3, 1);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (done) ok = 1'b1;
        end
        if (!ok) check("t7_reach", 64'd0, 64'd1);
        set_cfg(1, 32'h70, 3, 0, 1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("t7_valid", 64'(src_valid), 64'd1);
        check("t7_busy", 64'(busy), 64'd1);
        check("t7_sop", 64'(src_startofpacket), 64'd1);
        check("t7_data", 64'(src_data), 64'h70);
        wait_done("t7_timeout", 20, 1'b0);
        check("t7_beats", 64'(acc_d.size()), 64'd5);
        check("t7_pkt_cnt", 64'(pkt_cnt), 64'd1);
        check("t7_left", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
